// File: rtl/qedmma_corr_rx_pkg.sv
// Shared types and tdata field positions for the correlator result-stream receiver.
package qedmma_corr_rx_pkg;

  typedef enum logic [1:0] {
    TID_I   = 2'd0,
    TID_Q   = 2'd1,
    TID_MAG = 2'd2
  } tid_t;

  typedef enum logic [1:0] {
    RX_I,
    RX_Q,
    RX_MAG,
    RX_DROP
  } rx_state_t;

  localparam int IDX_LSB = 48;
  localparam int IDX_MSB = 57;

endpackage

// File: rtl/qedmma_corr_stream_rx_if.sv
// AXI-Stream beat bundle carrying correlator results {rsvd, lane_idx, value} tagged by tid.
interface qedmma_corr_stream_rx_if #(
  parameter int AXI_DATA_WIDTH = 64
);
  logic [AXI_DATA_WIDTH-1:0] tdata;
  logic                      tvalid;
  logic                      tlast;
  logic [1:0]                tid;
  logic                      tready;

  modport master (output tdata, tvalid, tlast, tid, input tready);
  modport slave  (input tdata, tvalid, tlast, tid, output tready);
endinterface

// File: rtl/qedmma_pingpong_ram.sv
// Two-bank simple-dual-port lane RAM; bank selects the upper address bit, read is registered.
module qedmma_pingpong_ram #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [0:(2**(ADDR_W+1))-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  // Read port output register: cleared by reset so the read data output starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[{rd_bank, rd_addr}];
  end
endmodule

// File: rtl/qedmma_corr_stream_rx.sv
// Correlator result-frame receiver: framing checks, ping-pong lane storage, peak tracking, frame handoff.
// Optional macro QEDMMA_RX_IQ_STORE_EN also stores I/Q sections and enables i_rd_sel.
module qedmma_corr_stream_rx
  import qedmma_corr_rx_pkg::*;
#(
  parameter int NUM_LANES      = 512,
  parameter int ACC_WIDTH      = 48,
  parameter int IDX_WIDTH      = 10,
  parameter int AXI_DATA_WIDTH = 64,
  localparam int ADDR_W        = $clog2(NUM_LANES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  qedmma_corr_stream_rx_if.slave s_axis,
  output logic                 o_frame_valid,
  output logic                 o_frame_bank,
  input  logic                 i_frame_release,
  input  logic [1:0]           i_rd_sel,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  output logic [ACC_WIDTH-1:0] o_rd_data,
  output logic [ADDR_W-1:0]    o_peak_lane,
  output logic [ACC_WIDTH-1:0] o_peak_mag,
  output logic [15:0]          o_frame_count,
  output logic                 o_err_seq,
  output logic                 o_err_idx,
  output logic                 o_err_last,
  input  logic                 i_err_clear
);
  rx_state_t            state;
  tid_t                 exp_tid;
  logic [IDX_WIDTH-1:0] exp_idx;
  logic [1:0]           full_count;
  logic                 wr_bank;
  logic [ACC_WIDTH-1:0] run_mag;
  logic [ADDR_W-1:0]    run_lane;
  logic [ACC_WIDTH-1:0] mag_rd_p1;

  logic [ACC_WIDTH-1:0] beat_val;
  logic [IDX_WIDTH-1:0] beat_idx;
  logic accept, in_frame, last_lane, hit_seq, hit_idx, hit_last, beat_err, beat_ok;
  logic mag_ok, commit, release_go, peak_take;
  logic unused_rsvd;

  assign beat_val    = s_axis.tdata[ACC_WIDTH-1:0];
  assign beat_idx    = s_axis.tdata[IDX_MSB:IDX_LSB];
  assign unused_rsvd = ^s_axis.tdata[AXI_DATA_WIDTH-1:IDX_MSB+1];

  assign s_axis.tready = (full_count < 2'd2);
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign in_frame      = (state != RX_DROP);
  assign last_lane     = (exp_idx == IDX_WIDTH'(NUM_LANES - 1));

  always_comb begin
    exp_tid = TID_I;
    case (state)
      RX_Q:    exp_tid = TID_Q;
      RX_MAG:  exp_tid = TID_MAG;
      default: exp_tid = TID_I;
    endcase
  end

  // Several violations may flag on the same beat.
  assign hit_seq    = accept && in_frame && (s_axis.tid != exp_tid);
  assign hit_idx    = accept && in_frame && (beat_idx != exp_idx);
  assign hit_last   = accept && in_frame && (s_axis.tlast != last_lane);
  assign beat_err   = hit_seq || hit_idx || hit_last;
  assign beat_ok    = accept && in_frame && !beat_err;
  assign mag_ok     = beat_ok && (state == RX_MAG);
  assign commit     = mag_ok && last_lane;
  assign release_go = i_frame_release && o_frame_valid;
  assign peak_take  = mag_ok && (beat_val > run_mag);

  assign o_frame_valid = (full_count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RX_I;
      exp_idx  <= '0;
      run_mag  <= '0;
      run_lane <= '0;
    end else begin
      if (state == RX_DROP) begin
        if (accept && s_axis.tid == TID_MAG && s_axis.tlast) state <= RX_I;
      end else if (beat_err) begin
        state   <= RX_DROP;
        exp_idx <= '0;
      end else if (beat_ok) begin
        if (last_lane) begin
          exp_idx <= '0;
          state   <= (state == RX_I) ? RX_Q : (state == RX_Q) ? RX_MAG : RX_I;
        end else begin
          exp_idx <= exp_idx + 1'b1;
        end
      end
      // Strict compare keeps the lowest lane on ties; cleared for the next frame.
      if (beat_err || commit) begin
        run_mag  <= '0;
        run_lane <= '0;
      end else if (peak_take) begin
        run_mag  <= beat_val;
        run_lane <= exp_idx[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_err_seq  <= 1'b0;
      o_err_idx  <= 1'b0;
      o_err_last <= 1'b0;
    end else begin
      o_err_seq  <= hit_seq  || (o_err_seq  && !i_err_clear);
      o_err_idx  <= hit_idx  || (o_err_idx  && !i_err_clear);
      o_err_last <= hit_last || (o_err_last && !i_err_clear);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_count    <= '0;
      wr_bank       <= 1'b0;
      o_frame_bank  <= 1'b0;
      o_frame_count <= '0;
      o_peak_lane   <= '0;
      o_peak_mag    <= '0;
    end else begin
      if (commit) begin
        o_peak_mag    <= peak_take ? beat_val : run_mag;
        o_peak_lane   <= peak_take ? exp_idx[ADDR_W-1:0] : run_lane;
        o_frame_count <= o_frame_count + 16'd1;
        wr_bank       <= ~wr_bank;
      end
      if (release_go) o_frame_bank <= ~o_frame_bank;
      case ({commit, release_go})
        2'b10:   full_count <= full_count + 2'd1;
        2'b01:   full_count <= full_count - 2'd1;
        default: full_count <= full_count;
      endcase
    end
  end

  qedmma_pingpong_ram #(.DATA_W(ACC_WIDTH), .ADDR_W(ADDR_W)) u_mag_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept && state == RX_MAG),
    .wr_bank (wr_bank),
    .wr_addr (beat_idx[ADDR_W-1:0]),
    .wr_data (beat_val),
    .rd_bank (o_frame_bank),
    .rd_addr (i_rd_addr),
    .rd_data (mag_rd_p1)
  );

`ifdef QEDMMA_RX_IQ_STORE_EN
  logic [ACC_WIDTH-1:0] i_rd_p1, q_rd_p1;
  logic [1:0]           rd_sel_p1;

  qedmma_pingpong_ram #(.DATA_W(ACC_WIDTH), .ADDR_W(ADDR_W)) u_i_ram (
    .clk(clk), .rst_n(rst_n), .wr_en(accept && state == RX_I), .wr_bank(wr_bank),
    .wr_addr(beat_idx[ADDR_W-1:0]), .wr_data(beat_val), .rd_bank(o_frame_bank),
    .rd_addr(i_rd_addr), .rd_data(i_rd_p1)
  );

  qedmma_pingpong_ram #(.DATA_W(ACC_WIDTH), .ADDR_W(ADDR_W)) u_q_ram (
    .clk(clk), .rst_n(rst_n), .wr_en(accept && state == RX_Q), .wr_bank(wr_bank),
    .wr_addr(beat_idx[ADDR_W-1:0]), .wr_data(beat_val), .rd_bank(o_frame_bank),
    .rd_addr(i_rd_addr), .rd_data(q_rd_p1)
  );

  // Section select is delayed to line up with the registered RAM outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_sel_p1 <= 2'd0;
    else        rd_sel_p1 <= i_rd_sel;
  end

  always_comb begin
    o_rd_data = '0;
    case (rd_sel_p1)
      2'd0:    o_rd_data = i_rd_p1;
      2'd1:    o_rd_data = q_rd_p1;
      2'd2:    o_rd_data = mag_rd_p1;
      default: o_rd_data = '0;
    endcase
  end
`else
  logic unused_rd_sel;
  assign unused_rd_sel = ^i_rd_sel;
  assign o_rd_data     = mag_rd_p1;
`endif

endmodule

// File: tb/tb_qedmma_corr_stream_rx.sv
// Randomized frame-level bench for qedmma_corr_stream_rx against a frame/bank reference model.
module tb_qedmma_corr_stream_rx;
  localparam int NL = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_valid, frame_bank, frame_release, err_clear;
  logic        err_seq, err_idx, err_last;
  logic [1:0]  rd_sel;
  logic [8:0]  rd_addr, peak_lane;
  logic [47:0] rd_data, peak_mag;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  qedmma_corr_stream_rx_if #(.AXI_DATA_WIDTH(64)) s_axis ();

  qedmma_corr_stream_rx dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis          (s_axis),
    .o_frame_valid   (frame_valid),
    .o_frame_bank    (frame_bank),
    .i_frame_release (frame_release),
    .i_rd_sel        (rd_sel),
    .i_rd_addr       (rd_addr),
    .o_rd_data       (rd_data),
    .o_peak_lane     (peak_lane),
    .o_peak_mag      (peak_mag),
    .o_frame_count   (frame_count),
    .o_err_seq       (err_seq),
    .o_err_idx       (err_idx),
    .o_err_last      (err_last),
    .i_err_clear     (err_clear)
  );

  // Reference model: committed frames per bank and handoff bookkeeping.
  logic [47:0] m_mag [2][NL];
  logic [47:0] fm [NL];
  int          m_full, m_count, m_peak_lane;
  logic [47:0] m_peak_mag;
  bit          m_rd_bank, m_wr_bank, m_seq, m_idx, m_last;
  int          n_checks = 0, n_errs = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_count = 0; m_peak_lane = 0; m_peak_mag = '0;
    m_rd_bank = 0; m_wr_bank = 0; m_seq = 0; m_idx = 0; m_last = 0;
  endtask

  task automatic check_status(input string tag);
    check({tag, ".tready"},  s_axis.tready, m_full < 2);
    check({tag, ".valid"},   frame_valid, m_full != 0);
    check({tag, ".bank"},    frame_bank, m_rd_bank);
    check({tag, ".count"},   frame_count, m_count);
    check({tag, ".pk_lane"}, peak_lane, m_peak_lane);
    check({tag, ".pk_mag"},  peak_mag, m_peak_mag);
    check({tag, ".e_seq"},   err_seq, m_seq);
    check({tag, ".e_idx"},   err_idx, m_idx);
    check({tag, ".e_last"},  err_last, m_last);
  endtask

  task automatic send_beat(input logic [1:0] tid, input int idx, input logic [47:0] val, input logic last);
    int n = 0;
    @(negedge clk);
    while (s_axis.tready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (s_axis.tready !== 1'b1) begin
      check("tready_wait", s_axis.tready, 1);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
    end
    s_axis.tdata  = {6'($urandom), 10'(idx), val};
    s_axis.tid    = tid;
    s_axis.tlast  = last;
    s_axis.tvalid = 1'b1;
    @(posedge clk);
    #1;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  // fault: 0 clean, 1 I lane skip, 2 early tlast in Q, 3 wrong tid in Mag. stop_at >= 0 aborts after that many beats.
  task automatic send_frame(input int fault, input bit rel_last, input int stop_at);
    int          beat = 0;
    int          full_before = m_full;
    logic [1:0]  tid;
    int          idx;
    logic        last;
    logic [47:0] v;
    for (int s = 0; s < 3; s++) begin
      for (int l = 0; l < NL; l++) begin
        if (stop_at >= 0 && beat >= stop_at) return;
        tid  = 2'(s);
        idx  = l;
        last = (l == NL - 1);
        v    = (s == 2) ? fm[l] : {16'($urandom), 32'($urandom)};
        if (fault == 1 && s == 0 && l == 5)   idx  = 6;
        if (fault == 2 && s == 1 && l == 100) last = 1'b1;
        if (fault == 3 && s == 2 && l == 200) tid  = 2'd1;
        if (rel_last && s == 2 && l == NL - 1) frame_release = 1'b1;
        send_beat(tid, idx, v, last);
        frame_release = 1'b0;
        beat++;
      end
    end
    if (fault == 1)      m_idx  = 1;
    else if (fault == 2) m_last = 1;
    else if (fault == 3) m_seq  = 1;
    else begin
      m_peak_mag = '0;
      m_peak_lane = 0;
      for (int l = 0; l < NL; l++) begin
        if (fm[l] > m_peak_mag) begin
          m_peak_mag  = fm[l];
          m_peak_lane = l;
        end
        m_mag[m_wr_bank][l] = fm[l];
      end
      m_wr_bank = !m_wr_bank;
      m_count   = (m_count + 1) & 16'hFFFF;
      m_full++;
    end
    if (rel_last && full_before > 0) begin
      m_full--;
      m_rd_bank = !m_rd_bank;
    end
  endtask

  task automatic do_release();
    @(negedge clk);
    frame_release = 1'b1;
    @(posedge clk);
    #1 frame_release = 1'b0;
    if (m_full > 0) begin
      m_full--;
      m_rd_bank = !m_rd_bank;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    err_clear = 1'b1;
    @(posedge clk);
    #1 err_clear = 1'b0;
    m_seq = 0; m_idx = 0; m_last = 0;
  endtask

  task automatic check_read(input int lane);
    @(negedge clk);
    rd_sel  = 2'd2;
    rd_addr = 9'(lane);
    @(posedge clk);
    #1 check("rd_data", rd_data, m_mag[m_rd_bank][lane]);
  endtask

  task automatic fill_rand();
    int a, b;
    for (int l = 0; l < NL; l++) fm[l] = {16'($urandom), 32'($urandom)} >> $urandom_range(0, 40);
    a = $urandom_range(0, 255);
    b = $urandom_range(256, NL - 1);
    fm[a] = 48'hFFFF_FFFF_FFFF;
    fm[b] = 48'hFFFF_FFFF_FFFF;
  endtask

  task automatic read_some();
    for (int k = 0; k < 4; k++) check_read($urandom_range(0, NL - 1));
  endtask

  initial begin
    s_axis.tdata = '0; s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0; s_axis.tid = 2'd0;
    frame_release = 1'b0; err_clear = 1'b0; rd_sel = 2'd2; rd_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_status("reset");
    @(negedge clk) rst_n = 1'b1;

    for (int l = 0; l < NL; l++) fm[l] = 48'(l);
    fm[300] = 48'h1234;
    send_frame(0, 0, -1);
    check_status("t1");
    check("t1.pk_lane_fixed", peak_lane, 300);
    check_read(300);
    check_read(0);
    check_read(NL - 1);

    fill_rand();
    send_frame(0, 0, -1);
    check_status("t2_full");
    do_release();
    check_status("t2_rel");
    read_some();
    do_release();
    check_status("t2_empty");

    fill_rand();
    send_frame(1, 0, -1);
    check_status("t3_err");
    fill_rand();
    send_frame(0, 0, -1);
    check_status("t3_ok");
    read_some();

    fill_rand();
    send_frame(2, 0, -1);
    check_status("t4_last");
    send_frame(3, 0, -1);
    check_status("t4_seq");
    do_clear();
    check_status("t4_clr");

    fill_rand();
    send_frame(0, 1, -1);
    check_status("t5");
    read_some();

    fill_rand();
    send_frame(0, 0, NL + 200);
    @(negedge clk) rst_n = 1'b0;
    #2 model_reset();
    check_status("t6_rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    fill_rand();
    send_frame(0, 0, -1);
    check_status("t6_new");
    read_some();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/qedmma_corr_stream_rx.md
Name: qedmma_corr_stream_rx

Overview:
AXI-Stream slave that receives correlator result frames (I section, then Q section, then magnitude section) from the dual-channel correlator output.
- Checks framing (tid order, lane index continuity, tlast placement) on every accepted beat.
- Stores magnitudes in a ping-pong lane buffer and tracks the per-frame peak.
- Hands complete frames to downstream CFAR/track logic via a frame-valid/release handshake and a random-access read port.

Parameters:
NUM_LANES, 512, lanes per section (beats per tid)
ACC_WIDTH, 48, accumulator/magnitude width, tdata[ACC_WIDTH-1:0]
IDX_WIDTH, 10, lane index field, tdata[ACC_WIDTH+IDX_WIDTH-1:ACC_WIDTH]
AXI_DATA_WIDTH, 64, tdata width; upper 6 bits reserved, ignored

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
s_axis_tdata  in  AXI_DATA_WIDTH  {rsvd, lane_idx, value}
s_axis_tvalid  in  1  beat valid
s_axis_tlast  in  1  last beat of section
s_axis_tid  in  2  0=I, 1=Q, 2=Mag
s_axis_tready  out  1  beat accepted when tvalid&&tready
o_frame_valid  out  1  committed frame available in read bank
o_frame_bank  out  1  bank index currently presented
i_frame_release  in  1  consumer frees presented bank (honoured only when o_frame_valid)
i_rd_sel  in  2  read section select (0=I, 1=Q, 2=Mag)
i_rd_addr  in  9  lane address into presented bank
o_rd_data  out  ACC_WIDTH  read data, 1-cycle latency
o_peak_lane  out  9  peak lane of last committed frame
o_peak_mag  out  ACC_WIDTH  peak magnitude of last committed frame
o_frame_count  out  16  committed frames, wraps at 0xFFFF->0
o_err_seq, o_err_idx, o_err_last  out  1 each  sticky framing errors
i_err_clear  in  1  clears sticky errors (set wins if same cycle)

Behaviour:
- Reset values: every output 0, except s_axis_tready=1. State RX_I, exp_idx=0, full_count=0, write bank 0, read bank 0, running peak 0.
- s_axis_tready = (full_count < 2); driven combinationally from registers only.
- States and transitions:
  - RX_I: expect tid=0.
  - RX_Q: expect tid=1.
  - RX_MAG: expect tid=2.
  - RX_DROP: discard beats after an error.
  - In RX_I/RX_Q/RX_MAG, every accepted beat must satisfy tid==expected, lane_idx==exp_idx, and tlast==(exp_idx==NUM_LANES-1).
  - Good beat with exp_idx < NUM_LANES-1: exp_idx++.
  - Good beat at the last lane: exp_idx=0; state advances I->Q->MAG.
  - Any violation sets the matching sticky flag (several may set in one beat), forces exp_idx=0, and moves to RX_DROP.
  - RX_DROP accepts and discards beats; it returns to RX_I after accepting a beat with tid=2 && tlast.
- Storage:
  - Mag beats write value to mag[wr_bank][lane] on acceptance.
  - Running peak: strict greater-than compare (unsigned), so on a tie the lowest lane wins. Reset to 0 at the start of each frame and on error.
- Commit: on the clean final MAG beat, the next cycle:
  - o_peak_lane/o_peak_mag update;
  - o_frame_count++;
  - full_count++;
  - wr_bank toggles;
  - o_frame_valid=1.
- Errored frames are never committed; the partially written bank is reused.
- Release: when i_frame_release && o_frame_valid, full_count-- and the read bank toggles.
  - Commit and release in the same cycle: full_count unchanged, both banks toggle.
- o_frame_valid = (full_count != 0).
- o_rd_data = registered read of [o_frame_bank][i_rd_sel][i_rd_addr].
  - i_rd_sel=3 returns 0.
  - Reads while !o_frame_valid return stale contents and are legal.
- Reset mid-frame: the partial frame is lost; no commit and no error flags.

Optional Feature:
QEDMMA_RX_IQ_STORE_EN
- Defined: I and Q values are also stored per bank; i_rd_sel selects the I, Q or Mag section.
- Undefined: I/Q beats are framing-checked only, then discarded. i_rd_sel is ignored and o_rd_data always returns Mag. Only the Mag RAM is instantiated.

Decomposition:
- Package qedmma_corr_rx_pkg holds:
  - tid_t enum (TID_I=0, TID_Q=1, TID_MAG=2);
  - rx_state_t enum (RX_I, RX_Q, RX_MAG, RX_DROP);
  - field constants IDX_LSB=48, IDX_MSB=57.
- Sub-module qedmma_pingpong_ram: two-bank simple-dual-port RAM, 1-cycle registered read, instantiated once per stored section.

Test Plan:
- Clean frame, Mag[lane]=lane except Mag[300]=0x1234, tready held 1 -> o_frame_valid=1 one cycle after the last beat; o_peak_lane=300, o_peak_mag=0x1234, o_frame_count=1; rd_addr=300 gives 0x1234 next cycle.
- Two clean frames with no release -> tready drops after the second commit; release -> tready returns to 1 and o_frame_bank toggles to 1.
- I section skips lane 5 (idx 4 then 6) -> o_err_idx=1; frame dropped, count unchanged; the next clean frame commits normally.
- tlast asserted at Q lane 100 -> o_err_last=1; tid=1 beat sent while in RX_MAG -> o_err_seq=1; i_err_clear clears both flags.
- Release and third-frame commit in the same cycle with full_count=1 -> full_count stays 1 and both banks toggle.
- rst_n asserted mid-Q-section -> all outputs reset, tready=1; a fresh full frame then commits with o_frame_count=1.
